riscv_fetch: RTL

Instruction fetch stage. It sits directly upstream of the instruction decoder and feeds it 32-bit instructions with their PCs.
- Holds the PC and issues word requests to instruction memory. Memory responses are in order, with variable latency and no backpressure.
- Buffers returned instructions in a small FIFO and presents them to decode through a valid/ready handshake.
- Accepts PC redirects from the branch/jump resolution logic and discards stale in-flight responses after a redirect.

---
 rtl/riscv_fetch.sv | 117 +++++++++++
 1 files changed

// File: rtl/riscv_fetch.sv
// Instruction fetch stage: credit-limited word requests to instruction memory, in-order PC
// tagging of responses, a small FIFO toward decode, and dropping of stale responses after redirects.
module riscv_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  output logic        imem_req_valid_out,
  input  logic        imem_req_ready_in,
  output logic [31:0] imem_addr_out,
  input  logic        imem_resp_valid_in,
  input  logic [31:0] imem_resp_data_in,
  input  logic        redirect_valid_in,
  input  logic [31:0] redirect_pc_in,
  output logic        inst_valid_out,
  input  logic        inst_ready_in,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W:0]   CREDITS  = (CNT_W + 1)'(DEPTH);

  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) return '0;
    return p + 1'b1;
  endfunction

  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0] fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
  logic [PTR_W-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;

  logic [31:0] tag_mem [DEPTH];
  logic [31:0] fifo_inst [DEPTH];
  logic [31:0] fifo_pc [DEPTH];

  logic credit_ok, accept, push, pop;
  logic unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc_in[1:0];

  // Credit counts both in-flight requests and buffered entries, so the FIFO can never overflow.
  assign credit_ok          = ({1'b0, outstanding_q} + {1'b0, fifo_cnt_q}) < CREDITS;
  assign imem_req_valid_out = !redirect_valid_in && credit_ok;
  assign imem_addr_out      = pc_q;
  assign accept             = imem_req_valid_out && imem_req_ready_in;

  assign inst_valid_out = (fifo_cnt_q != '0);
  assign inst_out       = inst_valid_out ? fifo_inst[fifo_rd_q] : 32'h0000_0013;
  assign pc_out         = inst_valid_out ? fifo_pc[fifo_rd_q] : 32'h0;
  assign pop            = inst_valid_out && inst_ready_in;

  // Every response in flight during a redirect belongs to the old stream and is discarded.
  assign push = imem_resp_valid_in && !redirect_valid_in && (drop_q == '0);

  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(imem_resp_valid_in);
    drop_d        = drop_q;
    fifo_cnt_d    = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    fifo_rd_d     = pop ? ptrInc(fifo_rd_q) : fifo_rd_q;
    fifo_wr_d     = push ? ptrInc(fifo_wr_q) : fifo_wr_q;
    tag_rd_d      = push ? ptrInc(tag_rd_q) : tag_rd_q;
    tag_wr_d      = accept ? ptrInc(tag_wr_q) : tag_wr_q;
    if (accept) pc_d = pc_q + 32'd4;
    if (imem_resp_valid_in && drop_q != '0) drop_d = drop_q - 1'b1;
    if (redirect_valid_in) begin
      pc_d       = {redirect_pc_in[31:2], 2'b00};
      drop_d     = outstanding_q - CNT_W'(imem_resp_valid_in);
      fifo_cnt_d = '0;
      fifo_rd_d  = '0;
      fifo_wr_d  = '0;
      tag_rd_d   = '0;
      tag_wr_d   = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      fifo_cnt_q    <= '0;
      fifo_rd_q     <= '0;
      fifo_wr_q     <= '0;
      tag_rd_q      <= '0;
      tag_wr_q      <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      fifo_cnt_q    <= fifo_cnt_d;
      fifo_rd_q     <= fifo_rd_d;
      fifo_wr_q     <= fifo_wr_d;
      tag_rd_q      <= tag_rd_d;
      tag_wr_q      <= tag_wr_d;
    end
  end

  // Storage needs no reset; the counters above decide which slots are meaningful.
  always_ff @(posedge clk_in) begin
    if (accept) tag_mem[tag_wr_q] <= pc_q;
    if (push) begin
      fifo_inst[fifo_wr_q] <= imem_resp_data_in;
      fifo_pc[fifo_wr_q]   <= tag_mem[tag_rd_q];
    end
  end

  respNeedsRequest: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    imem_resp_valid_in |-> (outstanding_q != '0));

endmodule
